alu_ctrl_decode: RTL and testbench

//  Decode stage that produces the 4-bit ALU command and operand selects consumed by the EX-stage ALU.

---
 rtl/alu_ctrl_decode.sv | 268 ++++++++++++++++++++++++++
 tb/tb_alu_ctrl_decode.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: RV32I decode stage producing the ALU command, operand selects,
// immediate and register indices for the EX stage. A 2-entry skid buffer (head E0,
// skid E1) sits behind the decoder, so in_ready and all out_* ports come from flops.
module alu_ctrl_decode #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_alu_ctrl,
    output logic [1:0]      out_srca_sel,
    output logic            out_srcb_sel,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            out_is_branch,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc
);

    typedef struct packed {
        logic [3:0]      alu_ctrl;
        logic [1:0]      srca_sel;
        logic            srcb_sel;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            reg_write;
        logic            is_branch;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } bundle_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [1:0] SRCA_RS1  = 2'd0;
    localparam logic [1:0] SRCA_PC   = 2'd1;
    localparam logic [1:0] SRCA_ZERO = 2'd2;

    // ALU command for the shared OP/OP-IMM funct3 table; alt selects sub/sra.
    function automatic logic [3:0] arith_alu(input logic [2:0] f3, input logic alt);
        logic [3:0] a;
        case (f3)
            3'b000:  a = alt ? 4'h1 : 4'h0;
            3'b001:  a = 4'h7;
            3'b010:  a = 4'h5;
            3'b011:  a = 4'h6;
            3'b100:  a = 4'h4;
            3'b101:  a = alt ? 4'h9 : 4'h8;
            3'b110:  a = 4'h3;
            3'b111:  a = 4'h2;
            default: a = 4'h0;
        endcase
        return a;
    endfunction

    // Full decode of one instruction word. Illegal words collapse to an all-zero
    // bundle carrying only the illegal flag and the pc. Operands that an
    // instruction does not use (rs1/rs2/rd, R-type imm) are reported as 0.
    function automatic bundle_t decode_instr(input logic [31:0] instr, input logic [XLEN-1:0] pc);
        bundle_t    b;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       ill;
        logic       wr;
        b   = '0;
        f3  = instr[14:12];
        f7  = instr[31:25];
        ill = 1'b0;
        wr  = 1'b0;
        b.rs1 = instr[19:15];
        case (instr[6:0])
            OPC_OP: begin
                wr         = 1'b1;
                b.rs2      = instr[24:20];
                b.alu_ctrl = arith_alu(f3, instr[30]);
                if (f7 == 7'b0000000) begin
                    ill = 1'b0;
                end else if ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))) begin
                    ill = 1'b0;
                end else begin
                    ill = 1'b1;
                end
            end
            OPC_OPIMM: begin
                wr         = 1'b1;
                b.srcb_sel = 1'b1;
                b.alu_ctrl = arith_alu(f3, (f3 == 3'b101) && instr[30]);
                if ((f3 == 3'b001) || (f3 == 3'b101)) begin
                    b.imm = {27'd0, instr[24:20]};
                    if (f7 == 7'b0000000) begin
                        ill = 1'b0;
                    end else if ((f7 == F7_ALT) && (f3 == 3'b101)) begin
                        ill = 1'b0;
                    end else begin
                        ill = 1'b1;
                    end
                end else begin
                    b.imm = {{20{instr[31]}}, instr[31:20]};
                end
            end
            OPC_LOAD, OPC_JALR: begin
                wr         = 1'b1;
                b.srcb_sel = 1'b1;
                b.imm      = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_STORE: begin
                b.srcb_sel = 1'b1;
                b.rs2      = instr[24:20];
                b.imm      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                b.rs2       = instr[24:20];
                b.is_branch = 1'b1;
                b.imm       = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                case (f3)
                    3'b000:  b.alu_ctrl = 4'hA;
                    3'b001:  b.alu_ctrl = 4'hB;
                    3'b100:  b.alu_ctrl = 4'h5;
                    3'b101:  b.alu_ctrl = 4'hC;
                    3'b110:  b.alu_ctrl = 4'h6;
                    3'b111:  b.alu_ctrl = 4'hD;
                    default: ill = 1'b1;
                endcase
            end
            OPC_LUI: begin
                wr         = 1'b1;
                b.rs1      = 5'd0;
                b.srca_sel = SRCA_ZERO;
                b.srcb_sel = 1'b1;
                b.imm      = {instr[31:12], 12'd0};
            end
            OPC_AUIPC: begin
                wr         = 1'b1;
                b.rs1      = 5'd0;
                b.srca_sel = SRCA_PC;
                b.srcb_sel = 1'b1;
                b.imm      = {instr[31:12], 12'd0};
            end
            OPC_JAL: begin
                wr         = 1'b1;
                b.rs1      = 5'd0;
                b.srca_sel = SRCA_PC;
                b.srcb_sel = 1'b1;
                b.imm      = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            // Also catches instr[1:0] != 2'b11: every listed opcode ends in 2'b11.
            default: ill = 1'b1;
        endcase
        if (ill) begin
            b         = '0;
            b.illegal = 1'b1;
        end else begin
            b.rd        = wr ? instr[11:7] : 5'd0;
            b.reg_write = wr && (instr[11:7] != 5'd0);
        end
        b.pc = pc;
        return b;
    endfunction

    state_t  state_r, state_s;
    bundle_t e0_r, e0_s;
    bundle_t e1_r, e1_s;
    bundle_t dec_s;
    logic    in_ready_r;
    logic    out_valid_r;
    logic    push_s;
    logic    pop_s;

    assign dec_s  = decode_instr(in_instr, in_pc);
    assign push_s = in_valid && in_ready_r;
    assign pop_s  = out_valid_r && out_ready;

    // Next-state and entry-update logic of the 2-entry skid buffer; flush wins.
    always_comb begin
        state_s = state_r;
        e0_s    = e0_r;
        e1_s    = e1_r;
        if (flush) begin
            state_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (push_s) begin
                        e0_s    = dec_s;
                        state_s = ONE;
                    end else begin
                        state_s = EMPTY;
                    end
                end
                ONE: begin
                    if (push_s && pop_s) begin
                        e0_s    = dec_s;
                        state_s = ONE;
                    end else if (push_s) begin
                        e1_s    = dec_s;
                        state_s = TWO;
                    end else if (pop_s) begin
                        state_s = EMPTY;
                    end else begin
                        state_s = ONE;
                    end
                end
                TWO: begin
                    if (pop_s) begin
                        e0_s    = e1_r;
                        state_s = ONE;
                    end else begin
                        state_s = TWO;
                    end
                end
                default: state_s = EMPTY;
            endcase
        end
    end

    // State, entry storage and the registered handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= EMPTY;
            e0_r        <= '0;
            e1_r        <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            e0_r        <= e0_s;
            e1_r        <= e1_s;
            in_ready_r  <= (state_s != TWO);
            out_valid_r <= (state_s != EMPTY);
        end
    end

    assign in_ready      = in_ready_r;
    assign out_valid     = out_valid_r;
    assign out_alu_ctrl  = e0_r.alu_ctrl;
    assign out_srca_sel  = e0_r.srca_sel;
    assign out_srcb_sel  = e0_r.srcb_sel;
    assign out_imm       = e0_r.imm;
    assign out_rs1       = e0_r.rs1;
    assign out_rs2       = e0_r.rs2;
    assign out_rd        = e0_r.rd;
    assign out_reg_write = e0_r.reg_write;
    assign out_is_branch = e0_r.is_branch;
    assign out_illegal   = e0_r.illegal;
    assign out_pc        = e0_r.pc;

endmodule

// File: tb/tb_alu_ctrl_decode.sv
// Bench for alu_ctrl_decode: directed instruction table with hand-derived expected
// bundles, a scoreboard queue filled on acceptance and drained on consumption.
module tb_alu_ctrl_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_alu_ctrl;
    logic [1:0]  out_srca_sel;
    logic        out_srcb_sel;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_is_branch;
    logic        out_illegal;
    logic [31:0] out_pc;

    alu_ctrl_decode #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_ctrl(out_alu_ctrl), .out_srca_sel(out_srca_sel), .out_srcb_sel(out_srcb_sel),
        .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_is_branch(out_is_branch),
        .out_illegal(out_illegal), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [3:0]  alu;
        logic [1:0]  srca;
        logic        srcb;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rw;
        logic        br;
        logic        ill;
        logic        chk_imm;
        logic        part;
    } exp_t;

    exp_t tv [12];
    exp_t sb [$];
    int   cur_idx;
    int   passed_n = 0;
    int   total_n  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_n++;
        assert (obs === exp) passed_n++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_tv(input int i, input logic [31:0] instr, input logic [3:0] alu,
                          input logic [1:0] srca, input logic srcb, input logic [31:0] imm,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic rw, input logic br, input logic ill,
                          input logic chk_imm, input logic part);
        tv[i].instr = instr; tv[i].pc = 32'h0000_1000 + 32'(i * 4);
        tv[i].alu = alu; tv[i].srca = srca; tv[i].srcb = srcb; tv[i].imm = imm;
        tv[i].rs1 = rs1; tv[i].rs2 = rs2; tv[i].rd = rd;
        tv[i].rw = rw; tv[i].br = br; tv[i].ill = ill;
        tv[i].chk_imm = chk_imm; tv[i].part = part;
    endtask

    // Scoreboard: compare the head bundle when consumed, record accepted inputs.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_bundle_pc", out_pc, 32'hDEAD_BEEF);
                end else begin
                    e = sb.pop_front();
                    chk("pc", out_pc, e.pc);
                    chk("alu_ctrl", 32'(out_alu_ctrl), 32'(e.alu));
                    chk("reg_write", 32'(out_reg_write), 32'(e.rw));
                    chk("is_branch", 32'(out_is_branch), 32'(e.br));
                    chk("illegal", 32'(out_illegal), 32'(e.ill));
                    if (!e.part) begin
                        chk("srca_sel", 32'(out_srca_sel), 32'(e.srca));
                        chk("srcb_sel", 32'(out_srcb_sel), 32'(e.srcb));
                        chk("rs1", 32'(out_rs1), 32'(e.rs1));
                        chk("rs2", 32'(out_rs2), 32'(e.rs2));
                        chk("rd", 32'(out_rd), 32'(e.rd));
                        if (e.chk_imm) chk("imm", out_imm, e.imm);
                    end
                end
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back(tv[cur_idx]);
        end
    end

    // Present one entry until accepted (bounded), then drop in_valid after the edge.
    task automatic send(input int idx);
        int n;
        in_valid = 1'b1;
        in_instr = tv[idx].instr;
        in_pc    = tv[idx].pc;
        cur_idx  = idx;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //        idx instr          alu   srca  sb  imm            rs1 rs2 rd  rw br ill ci pt
        set_tv(0,  32'hFFB10093, 4'h0, 2'd0, 1'b1, 32'hFFFFFFFB, 5'd2, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        set_tv(1,  32'h405201B3, 4'h1, 2'd0, 1'b0, 32'h0,        5'd4, 5'd5, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        set_tv(2,  32'h4030D093, 4'h9, 2'd0, 1'b1, 32'h3,        5'd1, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        set_tv(3,  32'h0020F063, 4'hD, 2'd0, 1'b0, 32'h0,        5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        set_tv(4,  32'hFFFFFFFF, 4'h0, 2'd0, 1'b0, 32'h0,        5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        set_tv(5,  32'h123452B7, 4'h0, 2'd2, 1'b1, 32'h12345000, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        set_tv(6,  32'h00000013, 4'h0, 2'd0, 1'b1, 32'h0,        5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        set_tv(7,  32'h0020A063, 4'h0, 2'd0, 1'b0, 32'h0,        5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        set_tv(8,  32'h0083B333, 4'h6, 2'd0, 1'b0, 32'h0,        5'd7, 5'd8, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        set_tv(9,  32'h0020A423, 4'h0, 2'd0, 1'b1, 32'h8,        5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        set_tv(10, 32'h010000EF, 4'h0, 2'd1, 1'b1, 32'h10,       5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        set_tv(11, 32'h40309093, 4'h0, 2'd0, 1'b0, 32'h0,        5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0;
        out_ready = 1'b1; cur_idx = 0;

        // Reset state.
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_alu_ctrl", 32'(out_alu_ctrl), 32'd0);
        chk("rst_imm", out_imm, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_reg_write", 32'(out_reg_write), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Decode table, one at a time, with one-cycle latency from acceptance.
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) begin
            send(i);
            @(negedge clk);
            chk("latency_out_valid", 32'(out_valid), 32'd1);
        end
        repeat (2) @(negedge clk);
        chk("drain_decode", 32'(sb.size()), 32'd0);

        // Backpressure: two accepts fill the buffer, third waits, order preserved.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(5);
        send(8);
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        send(10);
        repeat (4) @(negedge clk);
        chk("drain_backpressure", 32'(sb.size()), 32'd0);

        // Flush from TWO with a concurrent input.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(0);
        send(1);
        in_valid = 1'b1; in_instr = tv[10].instr; in_pc = tv[10].pc; cur_idx = 10;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush2_out_valid", 32'(out_valid), 32'd0);
        chk("flush2_in_ready", 32'(in_ready), 32'd1);

        // Flush from ONE while an input is actually accepted: it must be dropped.
        @(posedge clk); #1;
        send(2);
        in_valid = 1'b1; in_instr = tv[10].instr; in_pc = tv[10].pc; cur_idx = 10;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush1_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        send(3);
        repeat (2) @(negedge clk);
        chk("drain_flush", 32'(sb.size()), 32'd0);

        // Asynchronous reset while one entry is held.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(6);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        send(9);
        repeat (2) @(negedge clk);
        chk("drain_after_reset", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed_n, total_n);
        $finish;
    end

endmodule
